// File: rtl/decap_packet_stream.sv
// Reassembles one {addr, data} DFX word from a framed stream of Aurora beats
// and presents it on a valid/ready output, flagging malformed packet lengths.
module decap_packet_stream #(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int NUM_BEATS         =
        (DATA_DFX_WIDTH + AURORA_DATA_WIDTH - 1) / AURORA_DATA_WIDTH,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AURORA_DATA_WIDTH-1:0] data_in_dfx,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
    output logic                         valid_dfx_data,
    input  logic                         rd_output_port_0,
    output logic                         done_decap_pkt,
    output logic                         err_len,
    output logic [CNT_WIDTH-1:0]         pkt_cnt
);

    localparam int BW = $clog2(NUM_BEATS);
    localparam int AS = NUM_BEATS * AURORA_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD, DROP} state_t;

    state_t         state;
    logic [BW-1:0]  cnt;
    logic [AS-1:0]  asm_q;
    logic [AS-1:0]  asm_next;
    logic           accept;
    logic           take;
    logic           last_beat;

    // While holding a word, a new beat may only enter as the old word leaves.
    assign in_ready  = (state == HOLD) ? rd_output_port_0 : 1'b1;
    assign accept    = in_valid & in_ready;
    assign take      = valid_dfx_data & rd_output_port_0;
    assign last_beat = (cnt == BW'(NUM_BEATS - 1));

    always_comb begin
        asm_next = asm_q;
        asm_next[cnt*AURORA_DATA_WIDTH +: AURORA_DATA_WIDTH] = data_in_dfx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            asm_q          <= '0;
            data_dfx_recv  <= '0;
            valid_dfx_data <= 1'b0;
            done_decap_pkt <= 1'b0;
            err_len        <= 1'b0;
            pkt_cnt        <= '0;
        end else begin
            done_decap_pkt <= 1'b0;
            err_len        <= 1'b0;
            if (take) begin
                valid_dfx_data <= 1'b0;
                state          <= IDLE;
            end
            if (accept) begin
                if (state == DROP) begin
                    if (in_last) begin
                        state <= IDLE;
                    end
                end else if (last_beat) begin
                    cnt   <= '0;
                    asm_q <= '0;
                    if (in_last) begin
                        data_dfx_recv  <= asm_next[DATA_DFX_WIDTH-1:0];
                        valid_dfx_data <= 1'b1;
                        done_decap_pkt <= 1'b1;
                        pkt_cnt        <= pkt_cnt + 1'b1;
                        state          <= HOLD;
                    end else begin
                        err_len <= 1'b1;
                        state   <= DROP;
                    end
                end else if (in_last) begin
                    err_len <= 1'b1;
                    cnt     <= '0;
                    asm_q   <= '0;
                    state   <= IDLE;
                end else begin
                    asm_q <= asm_next;
                    cnt   <= cnt + 1'b1;
                    state <= COLLECT;
                end
            end
        end
    end

endmodule

// File: tb/tb_decap_packet_stream.sv
// Directed and randomized checks of decap_packet_stream against a
// packet-level reference model.
module tb_decap_packet_stream;

    localparam int AW  = 64;
    localparam int NB  = 17;
    localparam int DFX = 1034;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  din;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [DFX-1:0] data_dfx_recv;
    logic           valid_dfx_data;
    logic           rd;
    logic           done_decap_pkt;
    logic           err_len;
    logic [CW-1:0]  pkt_cnt;

    decap_packet_stream dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_dfx      (din),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .data_dfx_recv    (data_dfx_recv),
        .valid_dfx_data   (valid_dfx_data),
        .rd_output_port_0 (rd),
        .done_decap_pkt   (done_decap_pkt),
        .err_len          (err_len),
        .pkt_cnt          (pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit             m_valid;
    bit             m_drop;
    int             m_cnt;
    logic [AW-1:0]  m_buf [NB];
    logic [DFX-1:0] m_word;
    logic [CW-1:0]  m_pkt;
    bit             e_done;
    bit             e_err;

    logic [AW-1:0]  pkt_data [20];
    logic [DFX-1:0] saved;
    bit             rand_rd = 0;
    int             cyc = 0;
    int             last_done = 0;
    int             prev_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [DFX-1:0] obs,
                         input logic [DFX-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed_lo=%h expected_lo=%h",
                   tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic step(output bit acc);
        bit rdy;
        bit was_rst;
        logic [NB*AW-1:0] w;
        if (rand_rd) rd = ($urandom_range(0, 3) != 0);
        #1;
        was_rst = rst;
        rdy = m_valid ? rd : 1'b1;
        if (!rst) chk("in_ready", 64'(in_ready), 64'(rdy));
        acc = !rst && in_valid && rdy;
        e_done = 0;
        e_err  = 0;
        if (rst) begin
            m_valid = 0;
            m_drop  = 0;
            m_cnt   = 0;
            m_pkt   = '0;
            m_word  = '0;
        end else begin
            if (m_valid && rd) m_valid = 0;
            if (acc) begin
                if (m_drop) begin
                    if (in_last) m_drop = 0;
                end else begin
                    m_buf[m_cnt] = din;
                    m_cnt++;
                    if (m_cnt == NB) begin
                        m_cnt = 0;
                        if (in_last) begin
                            w = '0;
                            for (int k = 0; k < NB; k++)
                                w[k*AW +: AW] = m_buf[k];
                            m_word  = w[DFX-1:0];
                            m_valid = 1;
                            e_done  = 1;
                            m_pkt   = m_pkt + 1'b1;
                        end else begin
                            e_err  = 1;
                            m_drop = 1;
                        end
                    end else if (in_last) begin
                        e_err = 1;
                        m_cnt = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (done_decap_pkt) begin
            prev_done = last_done;
            last_done = cyc;
        end
        chk("valid", 64'(valid_dfx_data), 64'(m_valid));
        chk("done", 64'(done_decap_pkt), 64'(e_done));
        chk("err_len", 64'(err_len), 64'(e_err));
        chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
        if (m_valid || was_rst) chk_w("data", data_dfx_recv, m_word);
    endtask

    task automatic send_beat(input logic [AW-1:0] d, input bit last);
        bit acc;
        acc = 0;
        in_valid = 1;
        din      = d;
        in_last  = last;
        for (int t = 0; t < 50; t++) begin
            step(acc);
            if (acc) break;
        end
        if (!acc) begin
            failures++;
            $error("FAIL beat_accept_timeout observed=stalled required=accepted");
        end
    endtask

    task automatic send_pkt(input int n, input int last_idx, input bit gaps);
        bit acc;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 0;
                step(acc);
            end
            send_beat(pkt_data[i], i == last_idx);
        end
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 20; i++) pkt_data[i] = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 0;
        in_last  = 0;
        repeat (n) step(acc);
    endtask

    initial begin
        bit acc;
        int len;
        rst = 1; in_valid = 0; in_last = 0; din = '0; rd = 1;
        idle(2);
        rst = 0;

        // Single packet with a recognisable pattern
        for (int i = 0; i < 20; i++) pkt_data[i] = {32'(i), 32'(i)};
        send_pkt(17, 16, 0);
        chk("t1_lo", data_dfx_recv[63:0], 64'h0);
        chk("t1_addr", 64'(data_dfx_recv[1033:1024]), 64'h010);
        chk("t1_cnt", 64'(pkt_cnt), 64'd1);
        idle(2);

        // Backpressure: word held, next beat 0 stalls until rd rises
        rd = 0;
        fill_rand();
        send_pkt(17, 16, 0);
        saved = data_dfx_recv;
        fill_rand();
        in_valid = 1; din = pkt_data[0]; in_last = 0;
        repeat (5) begin
            step(acc);
            chk("bp_stall", 64'(acc), 64'd0);
            chk_w("bp_stable", data_dfx_recv, saved);
        end
        rd = 1;
        send_pkt(17, 16, 0);
        chk("bp_cnt", 64'(pkt_cnt), 64'd3);

        // Back-to-back packets with continuous input
        fill_rand();
        send_pkt(17, 16, 0);
        fill_rand();
        send_pkt(17, 16, 0);
        chk("b2b_gap", 64'(last_done - prev_done), 64'd17);
        chk("b2b_cnt", 64'(pkt_cnt), 64'd5);
        idle(1);

        // Short packet, then good packet with input gaps
        fill_rand();
        send_pkt(6, 5, 0);
        chk("short_cnt", 64'(pkt_cnt), 64'd5);
        fill_rand();
        send_pkt(17, 16, 1);

        // Long packet, then good packet
        fill_rand();
        send_pkt(20, 19, 0);
        fill_rand();
        send_pkt(17, 16, 0);
        chk("long_cnt", 64'(pkt_cnt), 64'd7);
        idle(1);

        // Reset in the middle of a packet
        fill_rand();
        for (int i = 0; i <= 8; i++) send_beat(pkt_data[i], 0);
        rst = 1; in_valid = 0;
        step(acc);
        chk("rst_valid", 64'(valid_dfx_data), 64'd0);
        chk("rst_cnt", 64'(pkt_cnt), 64'd0);
        chk_w("rst_data", data_dfx_recv, '0);
        rst = 0;
        fill_rand();
        send_pkt(17, 16, 0);
        chk("post_rst_cnt", 64'(pkt_cnt), 64'd1);

        // Randomized lengths and downstream readiness
        rand_rd = 1;
        for (int p = 0; p < 30; p++) begin
            fill_rand();
            case ($urandom_range(0, 3))
                0: len = $urandom_range(1, 16);
                1: len = $urandom_range(18, 20);
                default: len = 17;
            endcase
            send_pkt(len, len - 1, ($urandom_range(0, 1) == 1));
        end
        rand_rd = 0;
        rd = 1;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decap_packet_stream.md
Name: decap_packet_stream

Overview:
Parametrised successor to decap_packet. It reassembles one DFX word ({addr, data}, DATA_DFX_WIDTH bits) from a stream of AURORA_DATA_WIDTH-bit beats and presents it on a valid/ready output with backpressure. Unlike its predecessor it adds:
- input flow control and explicit packet framing (in_last);
- length-error detection and recovery;
- back-to-back packet acceptance and a delivered-packet counter.

It sits between the Aurora RX lane and the output-port queue.

Parameters:
DATA_WIDTH, 1024, payload bits per DFX word
ADDR_WIDTH, 10, address bits per DFX word
DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH, assembled word width
AURORA_DATA_WIDTH, 64, beat width
NUM_BEATS, ceil(DATA_DFX_WIDTH/AURORA_DATA_WIDTH) (=17), beats per packet; must be >=2
CNT_WIDTH, 16, width of pkt_cnt

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
data_in_dfx  in  AURORA_DATA_WIDTH  input beat
in_valid  in  1  beat present
in_last  in  1  final beat of packet
in_ready  out  1  beat accepted when in_valid&in_ready
data_dfx_recv  out  DATA_DFX_WIDTH  assembled word; addr in top ADDR_WIDTH bits
valid_dfx_data  out  1  data_dfx_recv valid
rd_output_port_0  in  1  downstream ready; word consumed when valid_dfx_data&rd_output_port_0
done_decap_pkt  out  1  one-cycle pulse when a good packet completes
err_len  out  1  one-cycle pulse on length error
pkt_cnt  out  CNT_WIDTH  count of good packets completed, wraps

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, beat counter=0, assembly register=0.
  - valid_dfx_data=0, done_decap_pkt=0, err_len=0, pkt_cnt=0, data_dfx_recv=0.
  - A partially assembled packet is discarded; reset has priority over every other event.
- Packing:
  - Beat k (k=0..NUM_BEATS-1) is written to bits [k*AW +: AW] of the assembly register.
  - On the last beat, bits above DATA_DFX_WIDTH-1 are dropped.
  - Indexed write; no shifting.
- States:
  - IDLE/COLLECT: in_ready=1. Each accepted beat stores and increments the counter.
  - HOLD: word presented. in_ready = rd_output_port_0 (combinational), which allows zero-bubble back-to-back packets.
  - DROP: in_ready=1. Beats are discarded until an accepted beat with in_last=1, then go to IDLE.
- Completion: accepted beat with counter==NUM_BEATS-1 and in_last=1 →
  - next cycle: data_dfx_recv = assembled word, valid_dfx_data=1, done_decap_pkt=1 for one cycle, pkt_cnt+1;
  - state=HOLD, counter=0.
  - Latency: last beat at edge N → valid at edge N+1.
- HOLD:
  - data_dfx_recv and valid_dfx_data are held stable until consumed.
  - On consumption without a simultaneous input beat: valid drops next cycle, state=IDLE.
  - On consumption with a simultaneous accepted beat: that beat is beat 0 of the next packet, state=COLLECT.
  - If that beat is also a completion (not possible, since NUM_BEATS>=2), no special handling is needed.
- Short packet: accepted beat with in_last=1 and counter<NUM_BEATS-1 →
  - err_len pulse next cycle;
  - assembly discarded, counter=0, state=IDLE;
  - no valid, pkt_cnt unchanged.
- Long packet: accepted beat with counter==NUM_BEATS-1 and in_last=0 →
  - err_len pulse next cycle;
  - packet discarded, state=DROP.
  - A word already in HOLD is unaffected by a later error (only reachable after its consumption).
- in_valid=0 stalls assembly indefinitely; no timeout.
- in_valid=1 with in_ready=0: the beat is not taken. The source must hold it.
- pkt_cnt wraps from 2^CNT_WIDTH-1 to 0.
- done_decap_pkt and err_len are never both 1.

Test Plan:
- Single packet: beat k = {32'hk, 32'hk}, k=0..16, in_last on k=16, rd_output_port_0=1 → one cycle after beat 16: valid_dfx_data=1, done_decap_pkt=1, data_dfx_recv[63:0]=64'h0_0, data_dfx_recv[1033:1024]=10'h010, pkt_cnt=1.
- Backpressure: same packet, rd_output_port_0=0 for 5 cycles after completion → valid held, data stable, in_ready=0, a second packet's beat 0 stalls. Raise rd → valid drops, beat 0 is accepted in the same cycle.
- Back-to-back: two 17-beat packets, continuous in_valid, rd=1 → two done pulses 17 cycles apart, pkt_cnt=2, no lost beats.
- Short packet: in_last on beat 5 → err_len=1 for one cycle, no valid, pkt_cnt unchanged; a following good packet completes normally.
- Long packet: 20 beats with in_last on beat 19 → err_len one cycle after beat 16, beats 17-19 dropped; next good packet gives pkt_cnt+1.
- Reset mid-packet: rst=1 after beat 8 → all outputs 0 next cycle; a new full packet after reset produces the correct word with no stale bits.
